// File: rtl/spram_rom_mbc_loader_pkg.sv
// Shared definitions for the SPRAM ROM loader: loader FSM states, bank
// geometry and the MBC1 bank-select decode.
package spram_rom_mbc_loader_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } load_state_e;

    localparam int unsigned BANK_BYTES      = 16384;
    localparam logic [15:0] BANK_LEN_M1     = 16'h3FFF;
    // gb_addr[14:13] value that selects the 0x2000-0x3FFF bank register window
    localparam logic [1:0]  MBC1_BANK_RANGE = 2'b01;

    // MBC1 bank-number rule: zero maps to one before the size mask is applied,
    // so a masked result of zero is still possible (e.g. 8 on an 8-bank ROM).
    function automatic logic [2:0] mbc1_bank_sel(input logic [4:0] raw, input logic [2:0] mask);
        if (raw == 5'd0) begin
            return 3'd1 & mask;
        end else begin
            return raw[2:0] & mask;
        end
    endfunction

endpackage

// File: rtl/spram_rom_mbc_loader_if.sv
// Command/data link between the ROM loader and the SPI flash reader.
interface spram_rom_mbc_loader_if;
    logic [23:0] flash_addr;
    logic [15:0] flash_len;
    logic        flash_go;
    logic        flash_rdy;
    logic [7:0]  flash_data;
    logic        flash_valid;

    modport master (output flash_addr, flash_len, flash_go,
                    input  flash_rdy, flash_data, flash_valid);
    modport slave  (input  flash_addr, flash_len, flash_go,
                    output flash_rdy, flash_data, flash_valid);
endinterface

// File: rtl/spram_rom_mbc_loader_mbc1_bank_reg.sv
// MBC1-style switchable ROM bank register, written through the 0x2000-0x3FFF window.
module spram_rom_mbc_loader_mbc1_bank_reg
    import spram_rom_mbc_loader_pkg::*;
#(
    parameter int unsigned ROM_BANKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gb_addr_hi_i,
    input  logic       gb_wr_stb_i,
    input  logic [4:0] gb_wdata_i,
    output logic [2:0] rom_bank_o
);

    localparam logic [2:0] BANK_MASK = 3'(ROM_BANKS - 1);

    logic [2:0] bank_q, bank_d;

    // Next bank: only strobes inside the bank-select window change it.
    always_comb begin
        bank_d = bank_q;
        if (gb_wr_stb_i && (gb_addr_hi_i == MBC1_BANK_RANGE)) begin
            bank_d = mbc1_bank_sel(gb_wdata_i, BANK_MASK);
        end else begin
            bank_d = bank_q;
        end
    end

    // Bank register; bank 1 is mapped at 0x4000 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= 3'd1;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign rom_bank_o = bank_q;

endmodule

// File: rtl/spram_rom_mbc_loader.sv
// Streams a ROM_BANKS x 16 KB image from SPI flash into SPRAM as 16-bit words,
// then serves cart-bus ROM reads with an MBC1 switchable bank at 0x4000-0x7FFF.
// Each SPRAM is a 16K x 16 registered-read array standing in for an
// SB_SPRAM256KA tied CHIPSELECT=1, STANDBY=0, SLEEP=0, POWEROFF=1, MASKWREN=4'b1111.
module spram_rom_mbc_loader
    import spram_rom_mbc_loader_pkg::*;
#(
    parameter int unsigned ROM_BANKS  = 8,
    parameter int unsigned NUM_SPRAM  = 4,
    parameter logic [23:0] FLASH_BASE = 24'h100000,
    parameter int unsigned RST_CYCLES = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [14:0]                   gb_addr_i,
    input  logic                          gb_wr_stb_i,
    input  logic [7:0]                    gb_wdata_i,
    output logic [7:0]                    rd_data_o,
    output logic                          rom_loaded_o,
    output logic [2:0]                    rom_bank_o,
    spram_rom_mbc_loader_if.master        flash
);

    localparam logic [2:0]  LAST_BANK   = 3'(ROM_BANKS - 1);
    localparam logic [13:0] LAST_BYTE   = 14'(BANK_BYTES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(RST_CYCLES - 1);

    load_state_e state_q, state_d;
    logic [2:0]  bank_q, bank_d;       // bank currently being loaded
    logic [13:0] cnt_q, cnt_d;         // byte index within the bank; bit 0 is the byte toggle
    logic [7:0]  low_q, low_d;         // even byte waiting for its odd partner
    logic [15:0] settle_q, settle_d;
    logic        go_q, go_d;
    logic        loaded_q, loaded_d;
    logic [23:0] flash_addr_q, flash_addr_d;
    logic        wr_en_s;

    logic [2:0]  bank_s;
    logic [16:0] ea_s;
    logic [13:0] spram_addr_s;
    logic [1:0]  sel_q;
    logic        lane_q;
    logic [15:0] word_s;
    logic [15:0] spram_dout_s [4];
    logic        unused_wdata_s;

    assign unused_wdata_s = ^gb_wdata_i[7:5];

    spram_rom_mbc_loader_mbc1_bank_reg #(.ROM_BANKS(ROM_BANKS)) u_bank (
        .clk          (clk),
        .rst          (rst),
        .gb_addr_hi_i (gb_addr_i[14:13]),
        .gb_wr_stb_i  (gb_wr_stb_i),
        .gb_wdata_i   (gb_wdata_i[4:0]),
        .rom_bank_o   (bank_s)
    );

    // Loader FSM: settle, request one bank at a time, pack bytes into words.
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        cnt_d    = cnt_q;
        low_d    = low_q;
        settle_d = settle_q;
        go_d     = 1'b0;
        loaded_d = loaded_q;
        wr_en_s  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_ISSUE;
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            ST_ISSUE: begin
                if (flash.flash_rdy) begin
                    go_d    = 1'b1;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_STREAM: begin
                if (flash.flash_valid) begin
                    cnt_d = cnt_q + 14'd1;
                    if (cnt_q[0] == 1'b0) begin
                        low_d = flash.flash_data;
                    end else begin
                        wr_en_s = 1'b1;
                    end
                    if (cnt_q == LAST_BYTE) begin
                        if (bank_q == LAST_BANK) begin
                            state_d  = ST_DONE;
                            loaded_d = 1'b1;
                        end else begin
                            bank_d  = bank_q + 3'd1;
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DONE: begin
                loaded_d = 1'b1;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
        flash_addr_d = FLASH_BASE + {7'd0, bank_d, 14'd0};
    end

    // Loader state and registered flash command outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT;
            bank_q       <= 3'd0;
            cnt_q        <= 14'd0;
            low_q        <= 8'd0;
            settle_q     <= 16'd0;
            go_q         <= 1'b0;
            loaded_q     <= 1'b0;
            flash_addr_q <= FLASH_BASE;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            cnt_q        <= cnt_d;
            low_q        <= low_d;
            settle_q     <= settle_d;
            go_q         <= go_d;
            loaded_q     <= loaded_d;
            flash_addr_q <= flash_addr_d;
        end
    end

    assign flash.flash_go   = go_q;
    assign flash.flash_addr = flash_addr_q;
    assign flash.flash_len  = BANK_LEN_M1;
    assign rom_loaded_o     = loaded_q;
    assign rom_bank_o       = bank_s;

    // Cart-bus effective address: 0x0000-0x3FFF fixed bank 0, 0x4000-0x7FFF switchable.
    always_comb begin
        if (gb_addr_i[14]) begin
            ea_s = {bank_s, gb_addr_i[13:0]};
        end else begin
            ea_s = {3'b000, gb_addr_i[13:0]};
        end
    end

    // SPRAM address: loader owns the port until the image is complete.
    always_comb begin
        if (loaded_q) begin
            spram_addr_s = ea_s[14:1];
        end else begin
            spram_addr_s = {bank_q[0], cnt_q[13:1]};
        end
    end

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_spram
        if (gi < NUM_SPRAM) begin : g_inst
            logic [15:0] mem_q [16384];
            logic [15:0] dout_q;
            logic        we_s;

            assign we_s = wr_en_s && (bank_q[2:1] == 2'(gi));

            // SPRAM array: full-word write, registered read.
            always_ff @(posedge clk) begin
                if (we_s) begin
                    mem_q[spram_addr_s] <= {flash.flash_data, low_q};
                end
                dout_q <= mem_q[spram_addr_s];
            end

            assign spram_dout_s[gi] = dout_q;
        end else begin : g_none
            assign spram_dout_s[gi] = 16'h0000;
        end
    end

    // SPRAM select and byte lane follow the registered read address by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= 2'd0;
            lane_q <= 1'b0;
        end else begin
            sel_q  <= ea_s[16:15];
            lane_q <= ea_s[0];
        end
    end

    // Output byte: odd addresses live in the upper half of each word.
    always_comb begin
        word_s = spram_dout_s[sel_q];
        if (lane_q) begin
            rd_data_o = word_s[15:8];
        end else begin
            rd_data_o = word_s[7:0];
        end
    end

endmodule

// File: tb/tb_spram_rom_mbc_loader.sv
// Bench for spram_rom_mbc_loader: two instances (4 banks over 2 SPRAMs, and
// 2 banks over 1 SPRAM) fed by behavioural flash readers, with a scoreboard
// queue of timed expectations checked by one monitor process.
module tb_spram_rom_mbc_loader;

    localparam logic [23:0] BASE = 24'h100000;
    localparam int K_RD = 0, K_BANK = 1, K_RESET = 2, K_LOADED = 3, K_GOCNT = 4, K_GOEND = 5;

    typedef struct {
        int          kind;
        int          inst;
        int unsigned due;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, rst_b, hold_a, hold_b;
    logic [14:0] addr_a, addr_b;
    logic        stb_a, stb_b;
    logic [7:0]  wd_a, wd_b, rd_a, rd_b;
    logic        ld_a, ld_b;
    logic [2:0]  bank_a, bank_b;

    spram_rom_mbc_loader_if fa ();
    spram_rom_mbc_loader_if fb ();

    spram_rom_mbc_loader #(.ROM_BANKS(4), .NUM_SPRAM(2)) dut_a (
        .clk(clk), .rst(rst_a), .gb_addr_i(addr_a), .gb_wr_stb_i(stb_a), .gb_wdata_i(wd_a),
        .rd_data_o(rd_a), .rom_loaded_o(ld_a), .rom_bank_o(bank_a), .flash(fa));

    spram_rom_mbc_loader #(.ROM_BANKS(2), .NUM_SPRAM(1)) dut_b (
        .clk(clk), .rst(rst_b), .gb_addr_i(addr_b), .gb_wr_stb_i(stb_b), .gb_wdata_i(wd_b),
        .rd_data_o(rd_b), .rom_loaded_o(ld_b), .rom_bank_o(bank_b), .flash(fb));

    // ROM image byte at image offset a
    function automatic logic [7:0] fpat(input int unsigned a);
        logic [16:0] v;
        v = a[16:0];
        return v[7:0] ^ v[15:8] ^ {7'd0, v[16]};
    endfunction

    function automatic logic [7:0] exp_rd(input logic [14:0] a, input int bank);
        int unsigned off;
        off = int'(a[13:0]);
        if (a[14]) off = off + 16384 * bank;
        return fpat(off);
    endfunction

    function automatic int next_bank(input int cur, input logic [14:0] a, input logic [7:0] d, input int banks);
        int b;
        if (a >= 15'h2000 && a <= 15'h3FFF) begin
            b = int'(d) % 32;
            if (b == 0) b = 1;
            return b % banks;
        end
        return cur;
    endfunction

    // Behavioural flash readers
    int unsigned a_rem, a_ptr, a_bytes, b_rem, b_ptr, b_bytes;
    logic a_busy, b_busy;
    assign fa.flash_rdy = !a_busy && !hold_a;
    assign fb.flash_rdy = !b_busy && !hold_b;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            a_busy <= 1'b0; fa.flash_valid <= 1'b0; fa.flash_data <= 8'd0;
            a_rem <= 0; a_ptr <= 0; a_bytes <= 0;
        end else if (fa.flash_go && fa.flash_rdy) begin
            a_busy <= 1'b1; a_ptr <= int'(fa.flash_addr - BASE); a_rem <= int'(fa.flash_len) + 1;
            fa.flash_valid <= 1'b0;
        end else if (a_busy && a_rem != 0) begin
            fa.flash_valid <= 1'b1; fa.flash_data <= fpat(a_ptr);
            a_ptr <= a_ptr + 1; a_rem <= a_rem - 1; a_bytes <= a_bytes + 1;
        end else begin
            fa.flash_valid <= 1'b0; a_busy <= 1'b0;
        end
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            b_busy <= 1'b0; fb.flash_valid <= 1'b0; fb.flash_data <= 8'd0;
            b_rem <= 0; b_ptr <= 0; b_bytes <= 0;
        end else if (fb.flash_go && fb.flash_rdy) begin
            b_busy <= 1'b1; b_ptr <= int'(fb.flash_addr - BASE); b_rem <= int'(fb.flash_len) + 1;
            fb.flash_valid <= 1'b0;
        end else if (b_busy && b_rem != 0) begin
            fb.flash_valid <= 1'b1; fb.flash_data <= fpat(b_ptr);
            b_ptr <= b_ptr + 1; b_rem <= b_rem - 1; b_bytes <= b_bytes + 1;
        end else begin
            fb.flash_valid <= 1'b0; b_busy <= 1'b0;
        end
    end

    // Scoreboard storage
    chk_t        chk_q[$];
    logic [23:0] go_exp_a[$], go_exp_b[$];
    int          n_tests = 0, n_fail = 0;
    int          go_cnt_a = 0, go_cnt_b = 0;

    task automatic cmp(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s inst=%0d t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    // Monitor: flash command checks and timed scoreboard expectations
    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [23:0] e;
        if (rst_a) go_cnt_a = 0;
        else if (fa.flash_go) begin
            go_cnt_a = go_cnt_a + 1;
            if (go_exp_a.size() != 0) e = go_exp_a.pop_front(); else e = 24'hFFFFFF;
            cmp("go_addr", 0, 32'(fa.flash_addr), 32'(e));
            cmp("go_len", 0, 32'(fa.flash_len), 32'h3FFF);
            cmp("go_rdy", 0, 32'(fa.flash_rdy), 32'd1);
        end
        if (rst_b) go_cnt_b = 0;
        else if (fb.flash_go) begin
            go_cnt_b = go_cnt_b + 1;
            if (go_exp_b.size() != 0) e = go_exp_b.pop_front(); else e = 24'hFFFFFF;
            cmp("go_addr", 1, 32'(fb.flash_addr), 32'(e));
            cmp("go_len", 1, 32'(fb.flash_len), 32'h3FFF);
            cmp("go_rdy", 1, 32'(fb.flash_rdy), 32'd1);
        end
        while (chk_q.size() != 0 && chk_q[0].due <= cyc) begin
            c = chk_q.pop_front();
            case (c.kind)
                K_RD:   cmp("rd_data", c.inst, 32'(c.inst == 0 ? rd_a : rd_b), c.exp);
                K_BANK: cmp("rom_bank", c.inst, 32'(c.inst == 0 ? bank_a : bank_b), c.exp);
                K_RESET: begin
                    cmp("rst_loaded", c.inst, 32'(c.inst == 0 ? ld_a : ld_b), 32'd0);
                    cmp("rst_go", c.inst, 32'(c.inst == 0 ? fa.flash_go : fb.flash_go), 32'd0);
                    cmp("rst_addr", c.inst, 32'(c.inst == 0 ? fa.flash_addr : fb.flash_addr), 32'(BASE));
                    cmp("rst_len", c.inst, 32'(c.inst == 0 ? fa.flash_len : fb.flash_len), 32'h3FFF);
                    cmp("rst_bank", c.inst, 32'(c.inst == 0 ? bank_a : bank_b), 32'd1);
                end
                K_LOADED: begin
                    cmp("loaded", c.inst, 32'(c.inst == 0 ? ld_a : ld_b), 32'd1);
                    cmp("load_bytes", c.inst, (c.inst == 0 ? a_bytes : b_bytes), c.exp);
                end
                K_GOCNT: cmp("go_count", c.inst, 32'(c.inst == 0 ? go_cnt_a : go_cnt_b), c.exp);
                K_GOEND: cmp("go_pending", c.inst, 32'(c.inst == 0 ? go_exp_a.size() : go_exp_b.size()), c.exp);
                default: cmp("bad_kind", c.inst, 32'(c.kind), 32'd0);
            endcase
        end
    end

    task automatic push(input int kind, input int inst, input logic [31:0] exp);
        chk_t c;
        c.kind = kind; c.inst = inst; c.due = cyc + 1; c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic do_rd(input int inst, input logic [14:0] a, input int bank);
        if (inst == 0) addr_a = a; else addr_b = a;
        push(K_RD, inst, 32'(exp_rd(a, bank)));
        @(negedge clk);
    endtask

    task automatic do_wr(input int inst, input logic [14:0] a, input logic [7:0] d, inout int bank, input int banks);
        if (inst == 0) begin addr_a = a; wd_a = d; stb_a = 1'b1; end
        else begin addr_b = a; wd_b = d; stb_b = 1'b1; end
        bank = next_bank(bank, a, d, banks);
        push(K_BANK, inst, 32'(bank));
        @(negedge clk);
        if (inst == 0) stb_a = 1'b0; else stb_b = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; hold_a = 1'b0; hold_b = 1'b1;
        addr_a = 15'd0; addr_b = 15'd0; stb_a = 1'b0; stb_b = 1'b0; wd_a = 8'd0; wd_b = 8'd0;
        repeat (3) @(negedge clk);
        fork
            begin : branch_a
                int bm;
                int i;
                bm = 1;
                push(K_RESET, 0, 32'd0);
                @(negedge clk);
                for (int k = 0; k < 4; k++) go_exp_a.push_back(BASE + 24'(k * 16384));
                rst_a = 1'b0;
                i = 0;
                while (i < 70000 && !ld_a) begin @(negedge clk); i++; end
                push(K_LOADED, 0, 32'd65536);
                @(negedge clk);
                push(K_GOCNT, 0, 32'd4);
                push(K_GOEND, 0, 32'd0);
                @(negedge clk);
                do_rd(0, 15'h0123, bm);
                do_rd(0, 15'h0124, bm);
                do_wr(0, 15'h2100, 8'h03, bm, 4);
                do_rd(0, 15'h4010, bm);
                do_wr(0, 15'h2100, 8'h00, bm, 4);
                do_rd(0, 15'h4010, bm);
                do_wr(0, 15'h2000, 8'h07, bm, 4);
                do_wr(0, 15'h3FFF, 8'h04, bm, 4);
                do_wr(0, 15'h0000, 8'h02, bm, 4);
                do_wr(0, 15'h6000, 8'h03, bm, 4);
                do_rd(0, 15'h7FFF, bm);
                for (int n = 0; n < 300; n++) begin
                    logic [14:0] ra;
                    ra = 15'($urandom_range(0, 32767));
                    if ($urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 1) == 0) ra = {2'b01, ra[12:0]};
                        do_wr(0, ra, 8'($urandom), bm, 4);
                    end else begin
                        do_rd(0, ra, bm);
                    end
                end
            end
            begin : branch_b
                int bm;
                int i;
                bm = 1;
                push(K_RESET, 1, 32'd0);
                @(negedge clk);
                go_exp_b.push_back(BASE);
                go_exp_b.push_back(BASE + 24'h004000);
                rst_b = 1'b0;
                repeat (128 + 50) @(negedge clk);
                push(K_GOCNT, 1, 32'd0);
                @(negedge clk);
                hold_b = 1'b0;
                i = 0;
                while (i < 40000 && b_bytes < 26384) begin @(negedge clk); i++; end
                rst_b = 1'b1;
                push(K_RESET, 1, 32'd0);
                @(negedge clk);
                @(negedge clk);
                go_exp_b.push_back(BASE);
                go_exp_b.push_back(BASE + 24'h004000);
                rst_b = 1'b0;
                i = 0;
                while (i < 40000 && !ld_b) begin @(negedge clk); i++; end
                push(K_LOADED, 1, 32'd32768);
                @(negedge clk);
                push(K_GOCNT, 1, 32'd2);
                push(K_GOEND, 1, 32'd0);
                @(negedge clk);
                do_rd(1, 15'h0123, bm);
                do_rd(1, 15'h4010, bm);
                do_wr(1, 15'h2100, 8'h03, bm, 2);
                do_wr(1, 15'h2100, 8'h02, bm, 2);
                do_rd(1, 15'h4011, bm);
                for (int n = 0; n < 60; n++) begin
                    logic [14:0] ra;
                    ra = 15'($urandom_range(0, 32767));
                    if ($urandom_range(0, 3) == 0) begin
                        ra = {2'b01, ra[12:0]};
                        do_wr(1, ra, 8'($urandom), bm, 2);
                    end else begin
                        do_rd(1, ra, bm);
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
